// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, mult/div EX occupancy,
// taken-branch flush, and a saturating count of stalled cycles.
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int LU_CYCLES = 1,
    parameter int MD_LAT    = 4,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             ID_MDStart,
    input  logic             Branch_Taken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] Stall_Count
);

    // state    | meaning
    // RUN      | normal issue; hazards evaluated here
    // LU_STALL | extra load-use stall cycles beyond the first
    // MD_WAIT  | mult/div occupies EX, front end frozen

    localparam int MAX_CYC = (LU_CYCLES > MD_LAT) ? LU_CYCLES : MD_LAT;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0]    LU_LOAD = CW'(LU_CYCLES - 1);
    localparam logic [CW-1:0]    MD_LOAD = CW'(MD_LAT - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {RUN, LU_STALL, MD_WAIT} stateT;

    stateT         state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          loadUse;

    assign loadUse = IDEX_MemRead && (IDEX_Rt != '0) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        MD_Busy     = 1'b0;
        case (state)
            RUN: begin
                // A taken branch squashes the ID instruction, so its hazards are moot
                if (Branch_Taken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end else if (loadUse) begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    if (LU_CYCLES > 1) begin
                        stateNext = LU_STALL;
                        cntNext   = LU_LOAD;
                    end
                end else if (ID_MDStart) begin
                    stateNext = MD_WAIT;
                    cntNext   = MD_LOAD;
                end
            end
            LU_STALL: begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                cntNext     = cnt - CNT_ONE;
                if (cnt == CNT_ONE) stateNext = RUN;
            end
            MD_WAIT: begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                MD_Busy     = 1'b1;
                cntNext     = cnt - CNT_ONE;
                if (cnt == CNT_ONE) stateNext = RUN;
            end
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase
        if (Reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            MD_Busy     = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= RUN;
            cnt         <= '0;
            Stall_Count <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (!PCWrite && (Stall_Count != SAT_MAX)) Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default, and LU_CYCLES=3 with a 4-bit
// counter) driven in lockstep against a cycle model through a scoreboard queue.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifidRs, ifidRt, idexRt;
    logic       ifidUsesRt, idexMemRead, idMdStart, branchTaken;

    logic        pcWriteA, ifidWriteA, ifidFlushA, idexBubbleA, mdBusyA;
    logic [15:0] stallCountA;
    logic        pcWriteB, ifidWriteB, ifidFlushB, idexBubbleB, mdBusyB;
    logic [3:0]  stallCountB;

    hazard_ctrl #(.REG_W(5), .LU_CYCLES(1), .MD_LAT(4), .CNT_W(16)) dutA (
        .Clk(clk), .Reset(rst), .IFID_Rs(ifidRs), .IFID_Rt(ifidRt),
        .IFID_UsesRt(ifidUsesRt), .IDEX_MemRead(idexMemRead), .IDEX_Rt(idexRt),
        .ID_MDStart(idMdStart), .Branch_Taken(branchTaken),
        .PCWrite(pcWriteA), .IFID_Write(ifidWriteA), .IFID_Flush(ifidFlushA),
        .IDEX_Bubble(idexBubbleA), .MD_Busy(mdBusyA), .Stall_Count(stallCountA));

    hazard_ctrl #(.REG_W(5), .LU_CYCLES(3), .MD_LAT(4), .CNT_W(4)) dutB (
        .Clk(clk), .Reset(rst), .IFID_Rs(ifidRs), .IFID_Rt(ifidRt),
        .IFID_UsesRt(ifidUsesRt), .IDEX_MemRead(idexMemRead), .IDEX_Rt(idexRt),
        .ID_MDStart(idMdStart), .Branch_Taken(branchTaken),
        .PCWrite(pcWriteB), .IFID_Write(ifidWriteB), .IFID_Flush(ifidFlushB),
        .IDEX_Bubble(idexBubbleB), .MD_Busy(mdBusyB), .Stall_Count(stallCountB));

    always #5 clk = ~clk;

    localparam int S_RUN = 0;
    localparam int S_LU  = 1;
    localparam int S_MD  = 2;

    typedef struct {int st; int cnt; int unsigned stall;} mdlT;
    typedef struct {bit pcw; bit ifw; bit flush; bit bubble; bit busy; int unsigned cnt;} expT;

    mdlT mA, mB;
    expT expQ[$];
    int  checkCount = 0;
    int  errorCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit luNow();
        return idexMemRead && (idexRt != 5'd0) &&
               ((idexRt == ifidRs) || (ifidUsesRt && (idexRt == ifidRt)));
    endfunction

    function automatic expT mdlOut(input mdlT m);
        expT e;
        e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m.stall};
        if (rst) begin
            e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        end else if (m.st == S_RUN) begin
            if (branchTaken) begin
                e.flush = 1'b1; e.bubble = 1'b1;
            end else if (luNow()) begin
                e.pcw = 1'b0; e.ifw = 1'b0; e.bubble = 1'b1;
            end
        end else begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.bubble = 1'b1;
            e.busy = (m.st == S_MD);
        end
        return e;
    endfunction

    function automatic mdlT mdlNext(input mdlT m, input int luC, input int mdL, input int unsigned maxC);
        mdlT n;
        expT e;
        n = m;
        e = mdlOut(m);
        if (rst) return '{S_RUN, 0, 0};
        if (!e.pcw && m.stall < maxC) n.stall = m.stall + 1;
        if (m.st == S_RUN) begin
            if (branchTaken) begin
                n.st = S_RUN;
            end else if (luNow()) begin
                if (luC > 1) begin n.st = S_LU; n.cnt = luC - 1; end
            end else if (idMdStart) begin
                n.st = S_MD; n.cnt = mdL - 1;
            end
        end else begin
            if (m.cnt == 1) n.st = S_RUN;
            n.cnt = m.cnt - 1;
        end
        return n;
    endfunction

    // Caller is at a falling edge; expectations are queued as stimulus is applied.
    task automatic drive(input int rs, input int rt, input int uses, input int mr,
                         input int exRt, input int md, input int br);
        ifidRs      = 5'(rs);
        ifidRt      = 5'(rt);
        ifidUsesRt  = 1'(uses);
        idexMemRead = 1'(mr);
        idexRt      = 5'(exRt);
        idMdStart   = 1'(md);
        branchTaken = 1'(br);
        expQ.push_back(mdlOut(mA));
        expQ.push_back(mdlOut(mB));
        step();
    endtask

    task automatic step();
        expT e;
        #1;
        e = expQ.pop_front();
        checkVal("A.PCWrite",     32'(pcWriteA),    32'(e.pcw));
        checkVal("A.IFID_Write",  32'(ifidWriteA),  32'(e.ifw));
        checkVal("A.IFID_Flush",  32'(ifidFlushA),  32'(e.flush));
        checkVal("A.IDEX_Bubble", 32'(idexBubbleA), 32'(e.bubble));
        checkVal("A.MD_Busy",     32'(mdBusyA),     32'(e.busy));
        checkVal("A.Stall_Count", 32'(stallCountA), e.cnt);
        e = expQ.pop_front();
        checkVal("B.PCWrite",     32'(pcWriteB),    32'(e.pcw));
        checkVal("B.IFID_Write",  32'(ifidWriteB),  32'(e.ifw));
        checkVal("B.IFID_Flush",  32'(ifidFlushB),  32'(e.flush));
        checkVal("B.IDEX_Bubble", 32'(idexBubbleB), 32'(e.bubble));
        checkVal("B.MD_Busy",     32'(mdBusyB),     32'(e.busy));
        checkVal("B.Stall_Count", 32'(stallCountB), e.cnt);
        @(posedge clk);
        mA = mdlNext(mA, 1, 4, 65535);
        mB = mdlNext(mB, 3, 4, 15);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resetBoth();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifidRs = '0; ifidRt = '0; idexRt = '0;
        ifidUsesRt = 1'b0; idexMemRead = 1'b0; idMdStart = 1'b0; branchTaken = 1'b0;
        mA = '{S_RUN, 0, 0};
        mB = '{S_RUN, 0, 0};
        @(negedge clk);
        idle(2);
        checkVal("rst.PCWrite", 32'(pcWriteA), 32'd0);
        checkVal("rst.Flush",   32'(ifidFlushA), 32'd1);
        rst = 1'b0;
        idle(1);

        // load-use on rs: one stall on A, three on B
        drive(5, 0, 0, 1, 5, 0, 0);
        idle(3);
        checkVal("lu.countA", 32'(stallCountA), 32'd1);
        checkVal("lu.countB", 32'(stallCountB), 32'd3);

        // rt match ignored when rt is not a source, stalls when it is
        resetBoth();
        for (int i = 0; i < 3; i++) drive(3, 7, 0, 1, 7, 0, 0);
        checkVal("rtUnused.countA", 32'(stallCountA), 32'd0);
        drive(3, 7, 1, 1, 7, 0, 0);
        idle(3);
        checkVal("rtUsed.countA", 32'(stallCountA), 32'd1);

        // loads to $zero never stall
        resetBoth();
        drive(0, 0, 1, 1, 0, 0, 0);
        checkVal("zero.countA", 32'(stallCountA), 32'd0);

        // mult/div: one advance cycle then MD_LAT-1 busy cycles
        resetBoth();
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(4);
        checkVal("md.countA", 32'(stallCountA), 32'd3);
        checkVal("md.busyA",  32'(mdBusyA), 32'd0);

        // branch dominates load-use and mult/div start
        resetBoth();
        drive(5, 0, 0, 1, 5, 1, 1);
        checkVal("br.countA", 32'(stallCountA), 32'd0);
        checkVal("br.busyA",  32'(mdBusyA), 32'd0);
        idle(1);

        // back-to-back mult/div with branch during the wait
        resetBoth();
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0, 1, (i == 2) ? 1 : 0);
        idle(4);
        checkVal("md2.countA", 32'(stallCountA), 32'd9);

        // async reset on the second MD_WAIT cycle
        resetBoth();
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        #2 rst = 1'b1;
        #1;
        checkVal("async.PCWrite", 32'(pcWriteA),    32'd0);
        checkVal("async.Flush",   32'(ifidFlushA),  32'd1);
        checkVal("async.Bubble",  32'(idexBubbleA), 32'd1);
        checkVal("async.Busy",    32'(mdBusyA),     32'd0);
        checkVal("async.Count",   32'(stallCountA), 32'd0);
        mA = '{S_RUN, 0, 0};
        mB = '{S_RUN, 0, 0};
        idle(1);
        rst = 1'b0;
        idle(1);
        checkVal("post.PCWrite", 32'(pcWriteA), 32'd1);
        checkVal("post.Busy",    32'(mdBusyA), 32'd0);
        checkVal("post.Count",   32'(stallCountA), 32'd0);

        // saturation of the 4-bit counter
        resetBoth();
        for (int i = 0; i < 20; i++) drive(5, 0, 0, 1, 5, 0, 0);
        checkVal("sat.countA", 32'(stallCountA), 32'd20);
        checkVal("sat.countB", 32'(stallCountB), 32'd15);
        idle(3);
        checkVal("sat.holdB", 32'(stallCountB), 32'd15);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
        end
        rst = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
